// File: rtl/generic_pipelined_accumulator_pkg.sv
// Shared types and sizing helpers for the slice-pipelined accumulator.
// Holds the readout state encoding and a ceil-log2 helper for counters.
package generic_pipelined_accumulator_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        DUMP  = 2'd2
    } state_t;

    // Bits needed to hold values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/generic_pipelined_accumulator_adder.sv
// Generic ripple adder with carry-in and carry-out; one per sum slice.
// Ports: a_i, b_i (WIDTH), ci_i -> s_o (WIDTH), co_o.
module generic_pipelined_accumulator_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ci_i,
    output logic [WIDTH-1:0] s_o,
    output logic             co_o
);

    assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i}
                       + {{WIDTH{1'b0}}, ci_i};

endmodule

// File: rtl/generic_pipelined_accumulator.sv
// Wide accumulator split into NSTAGES registered slices with registered
// inter-slice carries; a dump handshake drains the carries before readout.
// Ports: clk_i, rst_i (sync, active high), in_valid_i/in_ready_o/in_data_i
// sample stream, clear_i, dump_i, dump_clear_i, and the readout bundle
// acc_o, count_o, overflow_o qualified by the one-cycle acc_valid_o.
// NSTAGES must be at least 2 and divide WIDTH.
module generic_pipelined_accumulator
    import generic_pipelined_accumulator_pkg::*;
#(
    parameter int WIDTH     = 48,
    parameter int NSTAGES   = 3,
    parameter int IN_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [IN_WIDTH-1:0]  in_data_i,
    input  logic                 clear_i,
    input  logic                 dump_i,
    input  logic                 dump_clear_i,
    output logic [WIDTH-1:0]     acc_o,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 overflow_o,
    output logic                 acc_valid_o
);

    localparam int SW  = WIDTH / NSTAGES;
    localparam int DCW = clog2(NSTAGES + 1);

    state_t                      r_state;
    logic [DCW-1:0]              r_dcnt;
    logic                        r_dclr;
    logic [WIDTH-1:0]            r_acc;
    logic                        r_acc_valid;
    logic [CNT_WIDTH-1:0]        r_count;
    logic                        r_ovf;
    logic [NSTAGES-1:0][SW-1:0]  r_sum;
    logic [NSTAGES-2:0]          r_carry;

    logic                        w_accept;
    logic                        w_zero;
    logic [WIDTH-1:0]            w_in;
    logic [NSTAGES-1:0][SW-1:0]  w_chunk;
    logic [NSTAGES-1:0][SW-1:0]  w_sum_d;
    logic [NSTAGES-1:0]          w_co;
    logic [NSTAGES-1:0]          w_ci;

    assign in_ready_o  = (r_state == ACCUM);
    assign acc_o       = r_acc;
    assign count_o     = r_count;
    assign overflow_o  = r_ovf;
    assign acc_valid_o = r_acc_valid;

    // A sample offered alongside clear_i is dropped.
    assign w_accept = in_valid_i & in_ready_o & ~clear_i;
    assign w_in     = w_accept ? WIDTH'(in_data_i) : '0;
    assign w_zero   = rst_i | clear_i | ((r_state == DUMP) & r_dclr);
    assign w_ci     = {r_carry, 1'b0};

    for (genvar k = 0; k < NSTAGES; k++) begin : g_slice
        if (k == 0) begin : g_nodly
            assign w_chunk[k] = w_in[SW-1:0];
        end else begin : g_dly
            // Chunk k waits k cycles so it meets the carry of slice k-1.
            logic [SW-1:0] r_pipe [k];
            always_ff @(posedge clk_i) begin
                if (w_zero) begin
                    for (int i = 0; i < k; i++) r_pipe[i] <= '0;
                end else begin
                    r_pipe[0] <= w_in[k*SW +: SW];
                    for (int i = 1; i < k; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end
            assign w_chunk[k] = r_pipe[k-1];
        end

        generic_pipelined_accumulator_adder #(
            .WIDTH (SW)
        ) u_add (
            .a_i  (r_sum[k]),
            .b_i  (w_chunk[k]),
            .ci_i (w_ci[k]),
            .s_o  (w_sum_d[k]),
            .co_o (w_co[k])
        );
    end

    always_ff @(posedge clk_i) begin
        if (w_zero) begin
            r_sum   <= '0;
            r_carry <= '0;
        end else begin
            r_sum   <= w_sum_d;
            r_carry <= w_co[NSTAGES-2:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ACCUM;
            r_dcnt      <= '0;
            r_dclr      <= 1'b0;
            r_acc       <= '0;
            r_acc_valid <= 1'b0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_acc_valid <= 1'b0;
            if (clear_i || (r_state == DUMP && r_dclr)) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else begin
                if (w_accept && r_count != '1) r_count <= r_count + 1'b1;
                if (w_co[NSTAGES-1]) r_ovf <= 1'b1;
            end
            unique case (r_state)
                ACCUM: begin
                    if (dump_i) begin
                        r_state <= DRAIN;
                        r_dcnt  <= DCW'(NSTAGES);
                        r_dclr  <= dump_clear_i;
                    end
                end
                DRAIN: begin
                    if (r_dcnt == DCW'(1)) begin
                        r_state     <= DUMP;
                        r_acc_valid <= 1'b1;
                        // A clear in the last drain cycle must report 0.
                        r_acc       <= clear_i ? '0 : r_sum;
                    end else begin
                        r_dcnt <= r_dcnt - 1'b1;
                    end
                end
                DUMP: begin
                    r_state <= ACCUM;
                    r_dclr  <= 1'b0;
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

endmodule

// File: doc/generic_pipelined_accumulator.md
Name: generic_pipelined_accumulator

Overview:
- Wide, slice-pipelined accumulator that sums a stream of unsigned samples.
- The sum is split into NSTAGES slices. Each slice is one generic adder with carry-in and carry-out, plus a register; the carry between slices is registered.
- Sits downstream of the pulse/sample processing datapath. It supplies summed quantities (e.g. power/charge sums) to the readout logic.
- Readout is by a dump handshake that drains the carry pipeline before presenting a coherent result.

Parameters:
- WIDTH, 48, accumulator width in bits; must be divisible by NSTAGES.
- NSTAGES, 3, number of slices/pipeline stages; SW = WIDTH/NSTAGES bits per slice.
- IN_WIDTH, 32, sample width; IN_WIDTH <= WIDTH; zero-extended to WIDTH.
- CNT_WIDTH, 16, width of the accepted-sample counter.

Ports:
- clk_i  in  1  system clock; everything is synchronous to its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  sample present.
- in_ready_o  out  1  block accepts a sample this cycle.
- in_data_i  in  IN_WIDTH  unsigned sample.
- clear_i  in  1  synchronous clear of the sum, count and overflow.
- dump_i  in  1  request readout (level or pulse; sampled only in ACCUM).
- dump_clear_i  in  1  if high when dump_i is sampled, the sum/count/overflow are zeroed after the dump.
- acc_o  out  WIDTH  coherent sum; valid only while acc_valid_o is high.
- count_o  out  CNT_WIDTH  samples accepted since the last clear (saturating).
- overflow_o  out  1  sticky; carry-out of the top slice occurred.
- acc_valid_o  out  1  single-cycle strobe qualifying acc_o, count_o and overflow_o.

Behaviour:
- Reset values: acc_o=0, count_o=0, overflow_o=0, acc_valid_o=0, in_ready_o=1. All slice registers and carry registers are 0. State = ACCUM.
- Accept rule: a sample is accepted when in_valid_i & in_ready_o. in_ready_o=1 only in ACCUM.
- Skew:
  - Slice k (0 = LSB) adds bits [k*SW +: SW] of a sample accepted at cycle t at cycle t+k.
  - Slice k uses the carry registered by slice k-1 at cycle t+k-1.
  - Upper data chunks travel through k-deep delay registers. Non-accepted cycles inject zero chunks.
- Carry out of slice NSTAGES-1 sets overflow_o (sticky); the sum wraps modulo 2^WIDTH.
- count_o increments per accepted sample and saturates at all-ones.
- State machine:
  - ACCUM: dump_i=1 moves to DRAIN with cnt=NSTAGES. A sample accepted in the same cycle as dump_i is included in the sum.
  - DRAIN: only zeros are injected; cnt decrements each cycle; at cnt reaches 1, go to DUMP.
  - DUMP: for one cycle, acc_valid_o=1, acc_o = concatenated slice registers, count_o and overflow_o are stable. Next state is ACCUM. If the latched dump_clear is set, the sum, count, overflow and carries are zeroed on the same edge.
- Latency: dump_i sampled at cycle d gives acc_valid_o=1 in cycle d+NSTAGES+1 (d+4 at the default).
- acc_o is held (not cleared) outside DUMP; consumers must qualify it with acc_valid_o.
- clear_i:
  - Highest priority after rst_i, in any state.
  - Zeroes slices, carries, delay registers, count and overflow.
  - Does not change state. A dump in progress completes and reports 0.
  - A sample offered in the same cycle as clear_i is discarded, even though in_ready_o may be high.
- rst_i mid-DRAIN: return immediately to ACCUM with no acc_valid_o.
- Width rule: the top-slice carry-out is never added back; no other truncation.

Decomposition:
- Shared package holds:
  - state encoding constants ACCUM=2'd0, DRAIN=2'd1, DUMP=2'd2;
  - a constant function for ceil-log2 sizing of the drain counter.
- Natural sub-module: the existing generic adder, instantiated NSTAGES times with WIDTH=SW, CI from the carry register and CO to the next carry register.
- No other sub-modules; the skew delay lines are generated inline.

Test Plan:
- Reset: assert rst_i 2 cycles, then hold idle -> acc_valid_o=0, in_ready_o=1, count_o=0, overflow_o=0; dump_i at d -> acc_valid_o at d+4 with acc_o=0.
- Back-to-back samples: 0xFFFFFFFF x3 on consecutive cycles, dump_i on the third cycle -> acc_o=0x0002FFFFFFFD, count_o=3, overflow_o=0 at d+4.
- Slice-boundary carry: samples 0x0000FFFF then 0x00000001 -> acc_o=0x000000010000; then samples 0xFFFF0000 and 0x00010000 -> carry crosses into slice 2; acc_o=0x000100010000.
- Overflow (WIDTH=24, NSTAGES=3, IN_WIDTH=16): 257 samples of 0xFFFF -> acc_o=0x00FEFF, overflow_o=1, count_o=257; with dump_clear_i=1, a subsequent dump gives 0, overflow_o=0.
- Stall/priority: dump_i with in_valid_i in the same cycle -> sample included; in_ready_o=0 for cycles d+1..d+4, then 1; clear_i in DRAIN -> acc_valid_o still at d+4 with acc_o=0.
- Reset mid-drain: rst_i at d+2 -> no acc_valid_o; in_ready_o=1 at d+3; later sample 5 plus a dump -> acc_o=5.
